prng_key_gen: RTL
=================

# prng_key_gen

Parametrised successor to the single-word key PRNG. It produces complete ChaCha20 keys as a word-serial stream of `WORDS` × `N`-bit words from a Galois LFSR that jumps `N` steps per word, with optional entropy-bit injection. Words leave over a valid/ready handshake, and the block supports on-demand (single-key) and continuous modes. It sits between the seed source and the ChaCha20 state loader.

## Interface

Parameters:

- `N`, 32, word and LFSR width (≥ 8).
- `WORDS`, 8, words per key (≥ 2).
- `TAPS`, `32'h8020_0003`, Galois feedback mask for `x^32+x^22+x^2+x+1`. It must be overridden whenever `N` ≠ 32.
- `SEED_DEFAULT`, `32'h0000_0001`, the nonzero state substituted when the state would otherwise be zero.

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load the seed and arm the generator.
- `seed_load`  in  N  seed value captured on `start`.
- `seed_bit`  in  1  entropy bit XORed into state bit 0 on every advance.
- `req`  in  1  request one key; sampled only in ARMED.
- `cont_mode`  in  1  when 1, keys are generated back-to-back without `req`.
- `key_word`  out  N  current key word (the LFSR state).
- `key_valid`  out  1  `key_word` is valid.
- `key_ready`  in  1  downstream accepts the word.
- `key_idx`  out  `$clog2(WORDS)`  index of the current word within the key.
- `key_last`  out  1  `key_valid` && `key_idx == WORDS-1`.
- `ready`  out  1  the generator has been seeded.
- `busy`  out  1  state is GEN.
- `key_count`  out  16  number of completed keys; wraps modulo 2^16.

## Operation

- **States.** IDLE (unseeded), ARMED (seeded, waiting), GEN (emitting words).
- **Reset.** State → IDLE, LFSR → 0, `key_idx` → 0, `key_count` → 0. All outputs read 0.
- **Seeding.** `start` in any state loads LFSR ← `seed_load`, or ← `SEED_DEFAULT` if `seed_load == 0`. It also sets `key_idx` ← 0, `ready` ← 1, and state → ARMED.
  - `start` has priority over `req` and over any handshake in the same cycle.
  - `start` during GEN aborts the partial key. The aborted key does not increment `key_count`.
- **Leaving ARMED.** `req` or `cont_mode` moves ARMED → GEN. `req` in IDLE is ignored.
- **GEN.** `key_valid` = 1 and `key_word` = LFSR state.
  - On `key_valid && key_ready`, the LFSR advances by one jump and `key_idx` increments.
  - While `key_ready` = 0, `key_word` and `key_idx` hold stable.
- **Jump.** Apply `N` times: `s = (s >> 1) ^ (s[0] ? TAPS : 0)`. Then `s ^= {0, seed_bit}`. If the result is 0, substitute `SEED_DEFAULT`. The LFSR never holds 0 after seeding.
- **Last-word handshake.**
  - `key_idx` → 0 and `key_count` increments.
  - If `cont_mode` = 1, stay in GEN.
  - Otherwise go to ARMED.
- **Mode changes.** `cont_mode` is sampled only at ARMED exit and at the last-word handshake. Changing it mid-key does not truncate the key.
- **Arithmetic.** `key_idx` is unsigned and wraps from `WORDS-1` to 0. `key_count` wraps from 16'hFFFF to 0.

## Timing

- `start` at edge t: `ready` = 1 and state = ARMED visible after t.
- Request latency: `req` sampled high at edge t in ARMED gives `key_valid` = 1 in the cycle after t, with `key_word` = the seeded value for the first key.
- Throughput: with `key_ready` held high, one word per cycle and `WORDS` cycles per key.
  - `cont_mode`: no bubble between keys.
  - Single-key mode: `key_valid` drops the cycle after the `key_last` handshake.
- Outputs are registered state, except `key_last`, which is decoded from registered state. There is no combinational path from `key_ready` to `key_word` or `key_valid`.
- `rst` mid-key: next cycle matches the reset state; `ready` = 0 and a new `start` is required.

## Structure

- Package `prng_pkg` holds:
  - the state enum (IDLE, ARMED, GEN);
  - the default `TAPS` and `SEED_DEFAULT` constants for N = 32;
  - a `clog2`-based index width helper.
- Sub-module `lfsr_jump`: combinational, parameters `N` and `TAPS`. Inputs are state and `seed_bit`; output is the next state, including the zero substitution. Keeping it separate lets the bench unit-check it.
- Top level: FSM, `key_idx` and `key_count` counters, and the LFSR register.

## Test plan

- **Reset and zero seed.** Reset, then `start` with `seed_load = 0`, then `req`, with `key_ready = 1` and `seed_bit = 0`. Required: all outputs 0 after reset; `ready` = 1; first `key_word` = `32'h0000_0001`; words 1–7 match the software `lfsr_jump` model.
- **Single key.** Seed `32'hDEADBEEF`, pulse `req`, `seed_bit = 0`. Required: `key_word[0]` = `32'hDEADBEEF`; 8 consecutive valid cycles with `key_idx` 0..7; `key_last` only at idx 7; `key_count` = 1; `key_valid` = 0 on the following cycle.
- **Backpressure.** Drop `key_ready` for 5 cycles while idx = 3. Required: `key_word` and `key_idx` = 3 stable throughout; the remaining words are identical to the unstalled run.
- **Continuous mode.** Set `cont_mode = 1`, hold `key_ready = 1` for 24 cycles. Required: 24 consecutive valid words with no bubble; `key_count` = 3; `key_idx` wraps 7→0 twice.
- **Abort and reset.** `start` with seed `32'h1234_5678` while at idx 4, then `req`. Required: `key_valid` = 0 the next cycle; `key_count` unchanged; next key begins with `32'h1234_5678`. Separately, assert `rst` mid-key: all outputs 0 the next cycle, and `req` is ignored until `start`.

Source files
------------

// File: rtl/prng_key_gen_pkg.sv
// Shared types and constants for the word-serial ChaCha20 key generator.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_GEN   = 2'd2
  } prng_state_e;

  // Feedback mask for x^32+x^22+x^2+x+1 and the nonzero fallback state.
  localparam logic [31:0] DEF_TAPS         = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED_DEFAULT = 32'h0000_0001;

  function automatic int idx_w(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/prng_key_gen_if.sv
// Word-serial key stream: the generator drives the word, the consumer drives ready.
interface prng_key_gen_if
  import prng_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 8
);
  localparam int IW = idx_w(WORDS);

  logic [N-1:0]  key_word;
  logic          key_valid;
  logic          key_ready;
  logic [IW-1:0] key_idx;
  logic          key_last;

  modport master (
    output key_word,
    output key_valid,
    output key_idx,
    output key_last,
    input  key_ready
  );

  modport slave (
    input  key_word,
    input  key_valid,
    input  key_idx,
    input  key_last,
    output key_ready
  );
endinterface

// File: rtl/prng_key_gen_lfsr_jump.sv
// One N-step Galois LFSR jump with entropy injection into bit 0; never returns zero.
module lfsr_jump
  import prng_pkg::*;
#(
  parameter int           N            = 32,
  parameter logic [N-1:0] TAPS         = N'(DEF_TAPS),
  parameter logic [N-1:0] SEED_DEFAULT = N'(DEF_SEED_DEFAULT)
) (
  input  logic [N-1:0] i_state,
  input  logic         i_seed_bit,
  output logic [N-1:0] o_state
);

  logic [N-1:0] w_s;

  // Unrolled N shifts, then entropy XOR, then zero substitution.
  always_comb begin
    w_s = i_state;
    for (int k = 0; k < N; k++) begin
      w_s = {1'b0, w_s[N-1:1]} ^ (w_s[0] ? TAPS : {N{1'b0}});
    end
    w_s = w_s ^ {{(N-1){1'b0}}, i_seed_bit};
    if (w_s == {N{1'b0}}) begin
      o_state = SEED_DEFAULT;
    end else begin
      o_state = w_s;
    end
  end

endmodule

// File: rtl/prng_key_gen.sv
// Key generator top: seed/arm/generate FSM, word index and key counters, LFSR register.
module prng_key_gen
  import prng_pkg::*;
#(
  parameter int           N            = 32,
  parameter int           WORDS        = 8,
  parameter logic [N-1:0] TAPS         = N'(DEF_TAPS),
  parameter logic [N-1:0] SEED_DEFAULT = N'(DEF_SEED_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          seed_load,
  input  logic                  seed_bit,
  input  logic                  req,
  input  logic                  cont_mode,
  prng_key_gen_if.master        key_if,
  output logic                  ready,
  output logic                  busy,
  output logic [15:0]           key_count
);

  localparam int            IW       = idx_w(WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  prng_state_e   r_state;
  logic [N-1:0]  r_lfsr;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_count;
  logic          r_ready;
  logic          r_valid;

  prng_state_e   w_state_nxt;
  logic [N-1:0]  w_lfsr_nxt;
  logic [IW-1:0] w_idx_nxt;
  logic [15:0]   w_count_nxt;
  logic          w_ready_nxt;
  logic [N-1:0]  w_jump;
  logic          w_fire;
  logic          w_last;

  lfsr_jump #(
    .N            (N),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_jump (
    .i_state    (r_lfsr),
    .i_seed_bit (seed_bit),
    .o_state    (w_jump)
  );

  assign w_fire = r_valid && key_if.key_ready;
  assign w_last = (r_idx == IDX_LAST);

  // Next-state logic; start overrides everything, including a pending handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    w_ready_nxt = r_ready;
    if (start) begin
      w_state_nxt = ST_ARMED;
      w_lfsr_nxt  = (seed_load == {N{1'b0}}) ? SEED_DEFAULT : seed_load;
      w_idx_nxt   = {IW{1'b0}};
      w_ready_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ARMED: begin
          if (req || cont_mode) begin
            w_state_nxt = ST_GEN;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_GEN: begin
          if (w_fire) begin
            w_lfsr_nxt = w_jump;
            if (w_last) begin
              w_idx_nxt   = {IW{1'b0}};
              w_count_nxt = r_count + 16'd1;
              w_state_nxt = cont_mode ? ST_GEN : ST_ARMED;
            end else begin
              w_idx_nxt   = r_idx + IW'(1);
              w_state_nxt = ST_GEN;
            end
          end else begin
            w_state_nxt = ST_GEN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; key_valid is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lfsr  <= {N{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_count <= 16'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= (w_state_nxt == ST_GEN);
    end
  end

  assign key_if.key_word  = r_lfsr;
  assign key_if.key_valid = r_valid;
  assign key_if.key_idx   = r_idx;
  assign key_if.key_last  = r_valid && w_last;
  assign ready            = r_ready;
  assign busy             = r_valid;
  assign key_count        = r_count;

endmodule
